// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: state codes,
// opcodes, and the ALU/PC select values consumed by the datapath muxes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC      = 4'd7,
        S_ALU_WB    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_SEXT    = 2'b10;
    localparam logic [1:0] ALUSRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decode of the control state into datapath selects and strobes.
// mem_ready only qualifies the one-cycle IR/PC load at the end of FETCH.
module mc_ctrl_outputs
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal
);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = ALUSRCB_FOUR;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = ALUSRCB_SEXT_SH;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_SEXT;
            end
            S_MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM: state register, next-state sequencing,
// and the output decoder instance.
module mc_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_next;

    // The branch decision (PCWriteCond & zero) is formed in the datapath.
    logic zero_unused;
    assign zero_unused = zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_RST:       state_next = S_FETCH;
            S_FETCH:     if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC:      state_next = S_ALU_WB;
            S_ALU_WB:    state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_TRAP:      state_next = S_TRAP;
            // Unused codes recover through RST rather than lock up.
            default:     state_next = S_RST;
        endcase
    end

    assign state = state_q;

    mc_ctrl_outputs u_outputs (
        .state       (state_q),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and random instruction streams checked
// against per-instruction expected state traces and a per-state output table.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    mc_control_fsm dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    // Output vector order:
    // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource illegal
    logic [16:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

    function automatic logic [16:0] expected_outs(int st, logic mr);
        logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
        logic rdst = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin iord = 1; mrd = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin iord = 1; mwr = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rdst = 1; rw = 1; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            12: begin pw = 1; pcs = 2'b10; end
            15: ill = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive mem_ready away from the edge, then check state and outputs.
    task automatic step(input int exp_state, input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
        check("state", 32'(state), 32'(exp_state));
        check($sformatf("outs_s%0d", exp_state), 32'(outs), 32'(expected_outs(exp_state, mr)));
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'(outs), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release_state", 32'(state), 32'd0);
    endtask

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Expected trace of one instruction built from its class and wait counts.
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait,
                             input int trap_cycles);
        opcode = op;
        zero   = 1'($urandom);
        for (int i = 0; i < fetch_wait; i++) step(1, 1'b0);
        step(1, 1'b1);
        step(2, 1'($urandom));
        if (!is_legal(op)) begin
            for (int i = 0; i < trap_cycles; i++) step(15, 1'($urandom));
            do_reset();
        end else if (op == 6'b000000) begin
            step(7, 1'($urandom));
            step(8, 1'($urandom));
        end else if (op == 6'b100011) begin
            step(3, 1'($urandom));
            for (int i = 0; i < mem_wait; i++) step(4, 1'b0);
            step(4, 1'b1);
            step(5, 1'($urandom));
        end else if (op == 6'b101011) begin
            step(3, 1'($urandom));
            for (int i = 0; i < mem_wait; i++) step(6, 1'b0);
            step(6, 1'b1);
        end else if (op == 6'b000100) begin
            step(11, 1'($urandom));
        end else if (op == 6'b000010) begin
            step(12, 1'($urandom));
        end else begin
            step(9, 1'($urandom));
            step(10, 1'($urandom));
        end
    endtask

    initial begin
        logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b000010, 6'b001000};
        reset_n   = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("init_state", 32'(state), 32'd0);
        check("init_outs", 32'(outs), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_state", 32'(state), 32'd0);

        // Directed: R-type, lw with 3 wait cycles, sw, beq, fetch stall, jump, addi.
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 3, 0);
        run_instr(6'b101011, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000010, 2, 0, 0);
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b101011, 1, 2, 0);

        // Illegal opcode: sticky trap for 20 cycles, cleared by reset.
        run_instr(6'b111111, 0, 0, 20);

        // Asynchronous reset in the middle of a MEM_READ wait.
        opcode = 6'b100011;
        step(1, 1'b1);
        step(2, 1'b0);
        step(3, 1'b0);
        step(4, 1'b0);
        step(4, 1'b0);
        do_reset();
        run_instr(6'b100011, 0, 1, 0);

        // Random instruction stream, with occasional arbitrary opcodes.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else op = legal_ops[$urandom_range(0, 5)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                      int'($urandom_range(1, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
